tx_symbol_scheduler: RTL

TX_SYMBOL_SCHEDULER -- requirements
Module: tx_symbol_scheduler

---
 rtl/tx_symbol_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tx_symbol_scheduler.sv
// Transmit symbol scheduler: arbitrates packet beats, periodic SKP ordered sets and the
// compliance pattern onto a registered encoder interface, one symbol per INTERCLK.
module tx_symbol_scheduler #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3
) (
  input  logic       INTERCLK,
  input  logic       Reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_k,
  input  logic       tx_eop,
  output logic       tx_ready,
  input  logic       comp_req,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       enc_comp,
  output logic       skp_ovf
);

  // state | meaning
  // IDLE    | logical idle on the line, packet boundary
  // DATA    | packet beat (or in-packet idle) on the line
  // SKP_COM | K28.5 of a SKP ordered set on the line
  // SKP_SYM | K28.0 SKP symbol on the line
  // COMPL   | compliance pattern symbol on the line
  typedef enum logic [2:0] {IDLE, DATA, SKP_COM, SKP_SYM, COMPL} state_t;

  localparam logic [11:0] CNT_LAST = 12'(SKP_INTERVAL - 1);
  localparam logic [2:0]  SYM_LAST = 3'(SKP_LEN - 1);
  localparam logic [7:0]  K28_5    = 8'hBC;
  localparam logic [7:0]  K28_0    = 8'h1C;

  state_t      state, state_nxt;
  logic [11:0] skp_cnt;
  logic [1:0]  skp_pend;
  logic        in_pkt;
  logic        rdy_en;
  logic [2:0]  sym_cnt, sym_cnt_nxt;
  logic [1:0]  ph, ph_nxt;
  logic [7:0]  data_nxt;
  logic        k_nxt, comp_nxt;
  logic        accept, skp_inc, skp_dec, compl_exit;

  // Ready is only offered when the next symbol is guaranteed to be the beat.
  assign tx_ready = Reset && rdy_en && (state == IDLE || state == DATA) &&
                    (in_pkt || (!comp_req && skp_pend == 2'd0));
  assign accept   = tx_valid && tx_ready;
  assign skp_inc  = (state != COMPL) && (skp_cnt == CNT_LAST);

  always_comb begin
    state_nxt   = state;
    sym_cnt_nxt = sym_cnt;
    ph_nxt      = ph;
    data_nxt    = 8'h00;
    k_nxt       = 1'b0;
    comp_nxt    = 1'b0;
    skp_dec     = 1'b0;
    compl_exit  = 1'b0;
    case (state)
      IDLE, DATA: begin
        if (in_pkt) begin
          state_nxt = DATA;
          if (accept) begin
            data_nxt = tx_data;
            k_nxt    = tx_k;
          end
        end else if (comp_req) begin
          state_nxt = COMPL;
          ph_nxt    = 2'd0;
          data_nxt  = K28_5;
          k_nxt     = 1'b1;
          comp_nxt  = 1'b1;
        end else if (skp_pend != 2'd0) begin
          state_nxt = SKP_COM;
          data_nxt  = K28_5;
          k_nxt     = 1'b1;
        end else if (accept) begin
          state_nxt = DATA;
          data_nxt  = tx_data;
          k_nxt     = tx_k;
        end else begin
          state_nxt = IDLE;
        end
      end
      SKP_COM: begin
        state_nxt   = SKP_SYM;
        sym_cnt_nxt = 3'd0;
        data_nxt    = K28_0;
        k_nxt       = 1'b1;
      end
      SKP_SYM: begin
        if (sym_cnt == SYM_LAST) begin
          skp_dec = 1'b1;
          if (comp_req) begin
            state_nxt = COMPL;
            ph_nxt    = 2'd0;
            data_nxt  = K28_5;
            k_nxt     = 1'b1;
            comp_nxt  = 1'b1;
          end else if (skp_pend > 2'd1) begin
            state_nxt = SKP_COM;
            data_nxt  = K28_5;
            k_nxt     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          sym_cnt_nxt = sym_cnt + 3'd1;
          data_nxt    = K28_0;
          k_nxt       = 1'b1;
        end
      end
      COMPL: begin
        // ph names the symbol currently on the line; the pattern only ends after D10.2
        case (ph)
          2'd0: begin ph_nxt = 2'd1; data_nxt = 8'hB5; end
          2'd1: begin ph_nxt = 2'd2; data_nxt = K28_5; k_nxt = 1'b1; end
          2'd2: begin ph_nxt = 2'd3; data_nxt = 8'h4A; end
          default: begin
            if (comp_req) begin
              ph_nxt   = 2'd0;
              data_nxt = K28_5;
              k_nxt    = 1'b1;
              comp_nxt = 1'b1;
            end else begin
              compl_exit = 1'b1;
              state_nxt  = IDLE;
            end
          end
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge INTERCLK) begin
    if (!Reset) begin
      state    <= IDLE;
      sym_cnt  <= 3'd0;
      ph       <= 2'd0;
      enc_data <= 8'h00;
      enc_k    <= 1'b0;
      enc_comp <= 1'b0;
      skp_cnt  <= 12'd0;
      skp_pend <= 2'd0;
      skp_ovf  <= 1'b0;
      in_pkt   <= 1'b0;
      rdy_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      sym_cnt  <= sym_cnt_nxt;
      ph       <= ph_nxt;
      enc_data <= data_nxt;
      enc_k    <= k_nxt;
      enc_comp <= comp_nxt;
      rdy_en   <= 1'b1;
      if (accept) in_pkt <= !tx_eop;
      if (compl_exit) begin
        skp_cnt  <= 12'd0;
        skp_pend <= 2'd0;
      end else begin
        if (state != COMPL) skp_cnt <= skp_inc ? 12'd0 : skp_cnt + 12'd1;
        case ({skp_inc, skp_dec})
          2'b10: begin
            if (skp_pend == 2'd3) skp_ovf <= 1'b1;
            else                  skp_pend <= skp_pend + 2'd1;
          end
          2'b01:   skp_pend <= skp_pend - 2'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
